gf_div: RTL
===========

# gf_div

Sequential GF(2^8) inversion/division unit over the field defined by x^8+x^4+x^3+x^2+1 (0x11D; low byte 0x1D). It is the inverse operation of the team's GF(2^8) multiply/multiply-add unit and shares its trigger/status style and `gf_mult_pkg::status_e`. It computes b^-1 = b^254 by iterated square-and-multiply, and optionally a/b = a·b^-1. It sits beside the multiplier behind the same register-interface wrapper.

## Interface
- IO_WIDTH, 8, operand/result width (localparam, fixed).
- PP_CHAR, 29, low byte of the reduction polynomial 0x11D (localparam, fixed).
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- trigger_i  in  1  start request; sampled only in IDLE.
- op_a_i  in  8  dividend; used only when op_select_i=1.
- op_b_i  in  8  divisor / value to invert.
- op_select_i  in  1  0 = inverse (b^-1); 1 = divide (a/b).
- result_o  out  8  registered result; holds last result until next completion.
- done_o  out  1  one-cycle pulse: result_o valid.
- div_by_zero_o  out  1  valid with done_o; 1 when latched b = 0.
- status_o  out  status_e  IDLE when idle and accepting; PENDING otherwise.

## Operation
- State register values: IDLE, CALC, MULA, DONE.
- In IDLE with trigger_i=1:
  - Latch a_ff←op_a_i, x_ff←op_b_i, sel_ff←op_select_i, zero_ff←(op_b_i==0).
  - Set r_ff←0x01 and cnt←0, then go to CALC.
- CALC, one step per cycle, 7 steps, cnt 0..6:
  - x_n = gf_mul(x_ff, x_ff), r_n = gf_mul(r_ff, x_n).
  - Register x_ff←x_n and r_ff←r_n.
  - After step k: x = b^(2^k) and r = b^(2^(k+1)-2). After step 7: r = b^254.
- At cnt=6, go to MULA if sel_ff=1, else to DONE.
- MULA (one cycle): r_ff←gf_mul(r_ff, a_ff), then go to DONE.
- DONE (one cycle):
  - result_o←r_ff (or 0x00 if zero_ff), div_by_zero_o←zero_ff, done_o=1.
  - Next state is IDLE.
- gf_mul: carry-less 8×8 product into 15 bits, then reduce bits 14..8 from the top down by XOR of (0x1D << (k-8)) for each set bit k. The path is combinational; two chained instances are in CALC.
- b = 0:
  - The computation runs at full length; it naturally yields 0.
  - result_o = 0x00 and div_by_zero_o = 1 with done_o. No shortcut, so latency is constant.
- a = 0 with b ≠ 0: result 0x00, div_by_zero_o = 0.
- Inputs are latched at trigger. Input changes while busy have no effect.
- trigger_i in CALC, MULA or DONE is ignored, not queued. A new trigger is accepted in the first IDLE cycle after DONE.
- Reset mid-operation aborts the operation: all state returns to reset values and no done_o pulse is produced.

## Timing
- Reset values:
  - state IDLE, status_o IDLE.
  - result_o 0x00, done_o 0, div_by_zero_o 0.
  - x_ff, r_ff, a_ff, cnt, sel_ff and zero_ff all 0.
- Edge 0 samples trigger_i=1 in IDLE. status_o=PENDING from the cycle after edge 0.
- Inverse timing:
  - CALC occupies cycles 1–7 and DONE is cycle 8.
  - done_o is high in cycle 8 only, and result_o is valid from cycle 8.
- Divide timing:
  - CALC occupies cycles 1–7, MULA is cycle 8 and DONE is cycle 9.
- status_o returns to IDLE the cycle after DONE. Minimum trigger-to-trigger spacing is 9 cycles (inverse) or 10 cycles (divide).
- div_by_zero_o is updated together with result_o and holds until the next completion.
- done_o is registered and glitch-free.

## Test plan
- Reset, then inverse of b=0x02: done_o after exactly 8 cycles, result_o=0x8E, div_by_zero_o=0.
- Inverse of b=0x03 gives 0xF4 and inverse of b=0x01 gives 0x01. Also sweep all b=1..255 in inverse mode and check gf_mul(b, result_o)=0x01 for each.
- Divide a=0x04, b=0x02: done_o after exactly 9 cycles, result_o=0x02. Divide a=0x00, b=0x57: result_o=0x00, div_by_zero_o=0.
- b=0x00, op_select_i=1, a=0x33: result_o=0x00, div_by_zero_o=1, done_o after 9 cycles. The next valid operation clears div_by_zero_o.
- Hold trigger_i=1 continuously and change op_b_i during CALC:
  - Results match the operands latched at acceptance.
  - Operations are accepted back-to-back with no overlap; status_o=IDLE for exactly one cycle between them.
- Assert rst_ni=0 asynchronously during CALC cycle 4: all outputs go to 0/IDLE immediately, and no done_o pulse follows. After reset release, a fresh inverse of 0x02 returns 0x8E.

Source files
------------

// File: rtl/gf_div.sv
// Sequential GF(2^8) inverter/divider over x^8+x^4+x^3+x^2+1: computes b^254 by
// square-and-multiply, then optionally multiplies by a to form a/b.
package gf_mult_pkg;
  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } status_e;
endpackage

module gf_div (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  trigger_i,
  input  logic [7:0]            op_a_i,
  input  logic [7:0]            op_b_i,
  input  logic                  op_select_i,
  output logic [7:0]            result_o,
  output logic                  done_o,
  output logic                  div_by_zero_o,
  output gf_mult_pkg::status_e  status_o
);

  localparam int         IO_WIDTH = 8;
  localparam logic [7:0] PP_CHAR  = 8'd29;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_MULA,
    ST_DONE
  } state_e;

  // Carry-less product followed by top-down reduction of bits 14..8.
  function automatic logic [IO_WIDTH-1:0] gf_mul(input logic [IO_WIDTH-1:0] a,
                                                 input logic [IO_WIDTH-1:0] b);
    logic [2*IO_WIDTH-2:0] p;
    p = '0;
    for (int i = 0; i < IO_WIDTH; i++) begin
      if (b[i]) p = p ^ ((2*IO_WIDTH-1)'(a) << i);
    end
    for (int k = 2*IO_WIDTH-2; k >= IO_WIDTH; k--) begin
      if (p[k]) begin
        p[k] = 1'b0;
        p    = p ^ ((2*IO_WIDTH-1)'(PP_CHAR) << (k - IO_WIDTH));
      end
    end
    return p[IO_WIDTH-1:0];
  endfunction

  state_e              state_q, state_d;
  logic [IO_WIDTH-1:0] x_ff, r_ff, a_ff;
  logic [2:0]          cnt;
  logic                sel_ff, zero_ff;

  logic [IO_WIDTH-1:0] x_sq, mul_op, r_mul;

  // The r-side multiplier is shared: it takes x^2 in CALC and the dividend in MULA.
  assign x_sq   = gf_mul(x_ff, x_ff);
  assign mul_op = (state_q == ST_MULA) ? a_ff : x_sq;
  assign r_mul  = gf_mul(r_ff, mul_op);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    status_o = (state_q == ST_IDLE) ? gf_mult_pkg::IDLE : gf_mult_pkg::PENDING;
    case (state_q)
      ST_IDLE: if (trigger_i) state_d = ST_CALC;
      ST_CALC: if (cnt == 3'd6) state_d = sel_ff ? ST_MULA : ST_DONE;
      ST_MULA: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      x_ff          <= '0;
      r_ff          <= '0;
      a_ff          <= '0;
      cnt           <= '0;
      sel_ff        <= 1'b0;
      zero_ff       <= 1'b0;
      result_o      <= '0;
      done_o        <= 1'b0;
      div_by_zero_o <= 1'b0;
    end else begin
      state_q <= state_d;
      done_o  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (trigger_i) begin
            a_ff    <= op_a_i;
            x_ff    <= op_b_i;
            sel_ff  <= op_select_i;
            zero_ff <= (op_b_i == 8'h00);
            r_ff    <= 8'h01;
            cnt     <= '0;
          end
        end
        ST_CALC: begin
          x_ff <= x_sq;
          r_ff <= r_mul;
          cnt  <= cnt + 3'd1;
        end
        ST_MULA: r_ff <= r_mul;
        default: ;
      endcase
      // Outputs load on entry to DONE so done_o and result_o are valid in the DONE cycle.
      if (state_d == ST_DONE) begin
        done_o        <= 1'b1;
        result_o      <= zero_ff ? 8'h00 : r_mul;
        div_by_zero_o <= zero_ff;
      end
    end
  end

endmodule
